comb_sweep_ctrl: RTL
====================

# comb_sweep_ctrl

Sequencer that sweeps all 16 input vectors of a 4-input, 2-output combinational block (e.g. `comb_logic`) and captures its full truth table. It drives `{A,B,C,D}`, waits a programmable settle time, samples `Y1`/`Y2`, and accumulates result maps and ones-counts. It optionally checks the result against expected maps. It sits beside the combinational block as its test and characterisation controller.

## Interface
- `SETTLE`, default 1: number of cycles the vector is held before sampling; legal range 1..15.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled request to begin a sweep; only accepted in IDLE.
- `abort`  in  1  synchronous cancel of a running sweep.
- `y1`  in  1  Y1 output of the swept block.
- `y2`  in  1  Y2 output of the swept block.
- `exp_y1`  in  16  expected Y1 map; bit i is the expected value at vector i. Used only with the compare feature.
- `exp_y2`  in  16  expected Y2 map. Used only with the compare feature.
- `abcd`  out  4  vector driven to the block as {A,B,C,D}; A is the MSB.
- `busy`  out  1  high while in the WAIT or SAMPLE state.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `y1_map`  out  16  captured Y1 values; bit i holds the sample taken at vector i.
- `y2_map`  out  16  captured Y2 values.
- `y1_cnt`  out  5  number of sampled Y1 values equal to 1 (0..16).
- `y2_cnt`  out  5  number of sampled Y2 values equal to 1 (0..16).
- `err_cnt`  out  5  number of mismatched vectors (0..16).
- `first_err`  out  4  lowest vector index that mismatched.
- `pass`  out  1  sweep completed with no mismatch.

## Operation
- FSM states: IDLE, WAIT, SAMPLE, DONE.
- IDLE:
  - If `start`=1: clear maps, counts, `err_cnt`, `first_err` and `pass`; set `abcd`=0 and the settle counter to 0; go to WAIT.
- WAIT:
  - The settle counter increments each cycle.
  - When counter = SETTLE-1, go to SAMPLE.
- SAMPLE:
  - Write `y1_map[abcd]`=y1 and `y2_map[abcd]`=y2.
  - Add y1 to `y1_cnt` and y2 to `y2_cnt`.
  - A mismatch is `y1`≠`exp_y1[abcd]` or `y2`≠`exp_y2[abcd]`. On a mismatch, `err_cnt`+1; if this is the first mismatch (`err_cnt` was 0), also set `first_err`=`abcd`.
  - If `abcd`=15: go to DONE.
  - Otherwise: `abcd`+1, clear the settle counter, go to WAIT.
- DONE:
  - `done`=1 for exactly one cycle.
  - `pass` is set to (`err_cnt`=0), including the result of the final sample.
  - Go to IDLE. `start` is ignored in DONE.
- Results hold their values in IDLE until the next accepted `start`.
- `abcd` holds 15 after completion.
- `start` while busy is ignored.
- `abort`=1 in WAIT or SAMPLE:
  - Go to IDLE next cycle with no sample taken in that cycle and no `done`.
  - Partial maps and counts are retained; `pass`=0.
  - `abort` has priority over the SAMPLE transition.
  - `abort` in IDLE or DONE has no effect.
- Counts never overflow: at most 16 events, held in 5 bits.

## Timing
- Reset value of every output is 0: `abcd`, `busy`, `done`, maps, counts, `err_cnt`, `first_err`, `pass`. State resets to IDLE.
- Reset is asynchronous. Asserting `rst_n` mid-sweep immediately returns all outputs to 0 and the FSM to IDLE, with no `done`.
- All outputs are registered.
- `start` is sampled at edge T0. From T0+1, `busy`=1 and `abcd`=0.
- Each vector occupies SETTLE+1 cycles: SETTLE in WAIT plus 1 in SAMPLE.
- `y1`/`y2` are sampled at the edge ending the SAMPLE cycle. `abcd` has then been stable for SETTLE+1 cycles.
- `done` is high during cycle T0+16·(SETTLE+1)+1, with `busy`=0. With SETTLE=1 this is cycle T0+33.
- The earliest next `start` is accepted in the cycle after `done`.

## Configuration
- `COMB_SWEEP_CMP_EN` defined: the `exp_y1`/`exp_y2` compare logic is built, and `err_cnt`, `first_err` and `pass` behave as above.
- Not defined:
  - The compare logic is removed and `exp_*` are unused.
  - `err_cnt` and `first_err` are tied to 0.
  - `pass` pulses with `done`, i.e. it indicates completion only.
- Maps and counts are unaffected either way.

## Test plan
- Sweep `comb_logic`, SETTLE=1, `exp_y1`=16'hF9FF, `exp_y2`=16'h0E00:
  - `y1_map`=F9FF, `y2_map`=0E00, `y1_cnt`=14, `y2_cnt`=3, `err_cnt`=0, `pass`=1.
  - `done` exactly at T0+33.
- Same sweep with `exp_y1`=16'hFBFF:
  - `err_cnt`=1, `first_err`=9, `pass`=0.
  - With the macro undefined: `err_cnt`=0 and `pass`=1 at `done`.
- SETTLE=3, y1 tied to 1, y2 tied to 0:
  - `done` at T0+65; `y1_cnt`=16, `y2_cnt`=0.
  - `abcd` changes every 4 cycles.
- `abort` asserted during vector 5 SAMPLE:
  - Bit 5 of the maps is not written and `y1_cnt` does not include vector 5.
  - `busy`=0 next cycle; no `done`; `pass`=0.
- `start` re-asserted mid-sweep and during DONE:
  - No restart; the sweep completes normally with a single `done` pulse.
- `rst_n` asserted low at vector 8:
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release, a new `start` gives a full correct sweep.

Source files
------------

// File: rtl/comb_sweep_if.sv
// comb_sweep_if: request, stimulus and result bundle between comb_sweep_ctrl
// (slave) and the host that starts sweeps and reads back results (master).
interface comb_sweep_if;
  logic        start;
  logic        abort;
  logic        y1;
  logic        y2;
  logic [15:0] exp_y1;
  logic [15:0] exp_y2;
  logic [3:0]  abcd;
  logic        busy;
  logic        done;
  logic [15:0] y1_map;
  logic [15:0] y2_map;
  logic [4:0]  y1_cnt;
  logic [4:0]  y2_cnt;
  logic [4:0]  err_cnt;
  logic [3:0]  first_err;
  logic        pass;

  modport master (
    output start, abort, y1, y2, exp_y1, exp_y2,
    input  abcd, busy, done, y1_map, y2_map, y1_cnt, y2_cnt,
           err_cnt, first_err, pass
  );

  modport slave (
    input  start, abort, y1, y2, exp_y1, exp_y2,
    output abcd, busy, done, y1_map, y2_map, y1_cnt, y2_cnt,
           err_cnt, first_err, pass
  );
endinterface

// File: rtl/comb_sweep_ctrl.sv
// comb_sweep_ctrl: walks all 16 input vectors of a 4-in/2-out combinational
// block, holds each vector for SETTLE cycles, samples y1/y2, and records the
// truth-table maps and ones-counts.
// Build option COMB_SWEEP_CMP_EN: when defined, samples are compared against
// exp_y1/exp_y2 and err_cnt/first_err/pass report the outcome. When undefined,
// err_cnt/first_err read 0 and pass pulses together with done.
//
// state    | meaning
// S_IDLE   | results held, waiting for start
// S_WAIT   | vector driven, settle counter running
// S_SAMPLE | y1/y2 captured at the edge ending this cycle
// S_DONE   | sweep complete, done pulses for this one cycle
module comb_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input logic         clk,
  input logic         rst_n,
  comb_sweep_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [3:0]  r_abcd;
  logic [3:0]  r_settle_cnt;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_y1_map;
  logic [15:0] r_y2_map;
  logic [4:0]  r_y1_cnt;
  logic [4:0]  r_y2_cnt;
  logic        r_pass;

  logic        w_accept;
  logic        w_sample;
  logic        w_count;
  logic        w_last;
  logic        w_settled;

  assign w_last    = (r_abcd == 4'hF);
  assign w_settled = (r_settle_cnt == SETTLE_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-cycle control strobes; abort outranks sampling
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    w_count     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_settled) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_count = 1'b1;
        end
      end
      S_SAMPLE: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_sample    = 1'b1;
          w_state_nxt = w_last ? S_DONE : S_WAIT;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered status flags, decoded from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_WAIT) || (w_state_nxt == S_SAMPLE);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  // Vector index, settle counter, captured maps and ones-counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abcd       <= '0;
      r_settle_cnt <= '0;
      r_y1_map     <= '0;
      r_y2_map     <= '0;
      r_y1_cnt     <= '0;
      r_y2_cnt     <= '0;
    end else if (w_accept) begin
      r_abcd       <= '0;
      r_settle_cnt <= '0;
      r_y1_map     <= '0;
      r_y2_map     <= '0;
      r_y1_cnt     <= '0;
      r_y2_cnt     <= '0;
    end else if (w_sample) begin
      r_y1_map[r_abcd] <= bus.y1;
      r_y2_map[r_abcd] <= bus.y2;
      r_y1_cnt         <= r_y1_cnt + {4'd0, bus.y1};
      r_y2_cnt         <= r_y2_cnt + {4'd0, bus.y2};
      // abcd stays at 15 after the final vector
      if (!w_last) begin
        r_abcd       <= r_abcd + 4'd1;
        r_settle_cnt <= '0;
      end
    end else if (w_count) begin
      r_settle_cnt <= r_settle_cnt + 4'd1;
    end
  end

`ifdef COMB_SWEEP_CMP_EN
  logic [4:0] r_err_cnt;
  logic [3:0] r_first_err;
  logic       w_mismatch;

  assign w_mismatch = (bus.y1 != bus.exp_y1[r_abcd]) ||
                      (bus.y2 != bus.exp_y2[r_abcd]);

  // Mismatch tally; pass is resolved on entry to DONE so the last sample counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_pass      <= 1'b0;
    end else if (w_accept) begin
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_pass      <= 1'b0;
    end else if (w_sample) begin
      if (w_mismatch) begin
        r_err_cnt <= r_err_cnt + 5'd1;
        if (r_err_cnt == 5'd0) begin
          r_first_err <= r_abcd;
        end
      end
      if (w_last) begin
        r_pass <= (r_err_cnt == 5'd0) && !w_mismatch;
      end
    end
  end

  assign bus.err_cnt   = r_err_cnt;
  assign bus.first_err = r_first_err;
`else
  logic w_exp_unused;

  assign w_exp_unused = ^{bus.exp_y1, bus.exp_y2};

  // Without compare logic, pass only marks completion alongside done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass <= 1'b0;
    end else begin
      r_pass <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.err_cnt   = 5'd0;
  assign bus.first_err = 4'd0;
`endif

  assign bus.abcd   = r_abcd;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.y1_map = r_y1_map;
  assign bus.y2_map = r_y2_map;
  assign bus.y1_cnt = r_y1_cnt;
  assign bus.y2_cnt = r_y2_cnt;
  assign bus.pass   = r_pass;

endmodule
